// File: rtl/pad_mux_ctrl.sv
// ---------------------------------------------------------------------------
// pad_mux_ctrl
//   Wishbone-controlled pad multiplexer. Each pad carries a 2-bit mode
//   (00 peripheral, 01 software output, 1x tristate). Software writes a
//   SHADOW copy of the modes; a guarded IDLE -> DRAIN -> APPLY sequence then
//   moves the changed pads into the ACTIVE copy that really drives the pads.
//   While a sequence runs, the changed pads are held tristated so two drivers
//   never fight across a mode change.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_*                  Wishbone slave (one-cycle registered ack)
//   periph_out/periph_oeb  peripheral drive and active-low enable, per pad
//   periph_in              synchronized pad input, for pads in mode 00 only
//   pad_in                 raw asynchronous pad input
//   pad_out/pad_oeb        pad drive and active-low enable
// ---------------------------------------------------------------------------
module pad_mux_ctrl #(
   parameter int          NPADS     = 38,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [15:0] GUARD_RST = 16'd8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_dat_i,
   input  logic [31:0]      wbs_adr_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [NPADS-1:0] periph_out,
   input  logic [NPADS-1:0] periph_oeb,
   output logic [NPADS-1:0] periph_in,
   input  logic [NPADS-1:0] pad_in,
   output logic [NPADS-1:0] pad_out,
   output logic [NPADS-1:0] pad_oeb
);

   // Internal state is kept at the full 48-pad register-map width; bits of
   // pads that do not exist are forced to zero so they read 0 and never
   // differ between SHADOW and ACTIVE.
   localparam int                MAXP      = 48;
   localparam logic [MAXP-1:0]   PAD_VALID = {MAXP{1'b1}} >> (MAXP - NPADS);
   localparam logic [2*MAXP-1:0] SEL_VALID = {(2*MAXP){1'b1}} >> (2*MAXP - 2*NPADS);
   localparam logic [2*MAXP-1:0] SEL_RST   = {MAXP{2'b10}} & SEL_VALID;

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;

   state_t            state;
   logic [2*MAXP-1:0] shadow, active, target, mask2;
   logic [MAXP-1:0]   mask, out_r, sync1, sync2, diff, pad_in_w;
   logic [15:0]       guard, cnt;
   logic              wr_q;
   logic [2:0]        wr_idx;
   logic [31:0]       wr_dat;
   logic [3:0]        wr_sel;
   logic              ack_q;
   logic [31:0]       dat_q;
   logic              access, busy, pend;
   logic [31:0]       rd_data, wr_merged;
   logic              unused_adr;

   assign pad_in_w   = MAXP'(pad_in);
   assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

   assign access    = wbs_stb_i & wbs_cyc_i & ~ack_q &
                      (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign busy      = (state != IDLE);
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   // Byte-lane merge of new write data over the current register contents.
   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

   // Register-map view; nonexistent pads and CTRL[31:18] read as zero.
   function automatic logic [31:0] reg_word(input logic [2:0] idx);
      case (idx)
         3'd0:    return shadow[31:0];
         3'd1:    return shadow[63:32];
         3'd2:    return shadow[95:64];
         3'd3:    return out_r[31:0];
         3'd4:    return {16'h0, out_r[47:32]};
         3'd5:    return sync2[31:0];
         3'd6:    return {16'h0, sync2[47:32]};
         default: return {14'h0, pend, busy, guard};
      endcase
   endfunction

   // NOTE: every combinational output gets a default before any branch, so
   // no path through the block can leave a value held and infer a latch.
   always_comb begin
      diff  = '0;
      mask2 = '0;
      for (int p = 0; p < MAXP; p++) begin
         diff[p]         = (shadow[2*p +: 2] != active[2*p +: 2]);
         mask2[2*p +: 2] = {2{mask[p]}};
      end
      pend      = |(diff & ~mask);
      rd_data   = reg_word(wbs_adr_i[4:2]);
      wr_merged = merge(reg_word(wr_idx), wr_dat, wr_sel);
   end

   // Pad drive: pads caught in a running sequence stay tristated, the rest
   // follow their ACTIVE mode.
   always_comb begin
      pad_out   = '0;
      pad_oeb   = '1;
      periph_in = '0;
      for (int p = 0; p < NPADS; p++) begin
         if (!(busy && mask[p])) begin
            case (active[2*p +: 2])
               2'b00: begin
                  pad_out[p] = periph_out[p];
                  pad_oeb[p] = periph_oeb[p];
               end
               2'b01: begin
                  pad_out[p] = out_r[p];
                  pad_oeb[p] = 1'b0;
               end
               default: ;
            endcase
         end
         periph_in[p] = (active[2*p +: 2] == 2'b00) & sync2[p];
      end
   end

   // Bus, synchronizer, register writes and the drain/apply sequencer.
   // A write is captured with the access and committed at the end of the
   // ack cycle, so its effect on the pads shows the cycle after ack.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         shadow <= SEL_RST;
         active <= SEL_RST;
         target <= SEL_RST;
         mask   <= '0;
         out_r  <= '0;
         guard  <= GUARD_RST;
         cnt    <= '0;
         sync1  <= '0;
         sync2  <= '0;
         wr_q   <= 1'b0;
         wr_idx <= '0;
         wr_dat <= '0;
         wr_sel <= '0;
         ack_q  <= 1'b0;
         dat_q  <= '0;
      end else begin
         ack_q <= access;
         dat_q <= (access && !wbs_we_i) ? rd_data : 32'h0;
         wr_q  <= access & wbs_we_i;
         if (access) begin
            wr_idx <= wbs_adr_i[4:2];
            wr_dat <= wbs_dat_i;
            wr_sel <= wbs_sel_i;
         end

         sync1 <= pad_in_w;
         sync2 <= sync1;

         if (wr_q) begin
            case (wr_idx)
               3'd0: shadow[31:0]  <= wr_merged & SEL_VALID[31:0];
               3'd1: shadow[63:32] <= wr_merged & SEL_VALID[63:32];
               3'd2: shadow[95:64] <= wr_merged & SEL_VALID[95:64];
               3'd3: out_r[31:0]   <= wr_merged & PAD_VALID[31:0];
               3'd4: out_r[47:32]  <= wr_merged[15:0] & PAD_VALID[47:32];
               3'd7: guard         <= wr_merged[15:0];
               default: ;  // IN_LO / IN_HI are read-only
            endcase
         end

         case (state)
            IDLE: begin
               if (|diff) begin
                  state  <= DRAIN;
                  mask   <= diff;
                  // Snapshot the target modes: a later SEL write to a pad
                  // already in flight waits for the next sequence.
                  target <= shadow;
                  cnt    <= guard;
               end
            end
            DRAIN: begin
               if (cnt == 16'd0) state <= APPLY;
               else              cnt   <= cnt - 16'd1;
            end
            APPLY: begin
               active <= (active & ~mask2) | (target & mask2);
               mask   <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pad_mux_ctrl.md
PAD_MUX_CTRL -- requirements
Module: pad_mux_ctrl

Interface
REQ-001 Parameter NPADS, default 38, number of controlled pads; legal range 1..48.
REQ-002 Parameter BASE_ADDR, default 32'h3000_0000, Wishbone base; decode compares adr_i[31:8] with BASE_ADDR[31:8].
REQ-003 Parameter GUARD_RST, default 16'd8, reset value of GUARD.
REQ-004 One clock; reset is synchronous and active-high: wb_clk_i  in  1  clock; wb_rst_i  in  1  synchronous active-high reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
REQ-006 wbs_sel_i  in  4  byte lanes; wbs_dat_i  in  32  write data; wbs_adr_i  in  32  address.
REQ-007 wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-008 periph_out, periph_oeb  in  NPADS each  peripheral pad drive and active-low enable.
REQ-009 periph_in  out  NPADS  pad input forwarded to peripherals.
REQ-010 pad_in  in  NPADS  raw pad input (asynchronous).
REQ-011 pad_out, pad_oeb  out  NPADS each  pad drive and active-low enable.

Function
REQ-012 Per-pad 2-bit mode: 00 peripheral, 01 software output, 10 and 11 tristate.
REQ-013 Register map (adr_i[4:2]): 0 SEL0 pads 0-15; 1 SEL1 pads 16-31; 2 SEL2 pads 32-47; 3 OUT_LO; 4 OUT_HI; 5 IN_LO (ro); 6 IN_HI (ro); 7 CTRL = {PEND[17], BUSY[16], GUARD[15:0]}, bits 17:16 ro.
REQ-014 Bits for pads >= NPADS and bits 31:18 of CTRL read 0 and ignore writes.
REQ-015 Writes honour wbs_sel_i per byte; writes to ro fields are ignored.
REQ-016 Access = stb & cyc & address match & !ack; ack asserts the next cycle for exactly one cycle, with read data valid in that cycle; wbs_dat_o is 0 when ack is low.
REQ-017 SEL writes update SHADOW only; SEL reads return SHADOW.
REQ-018 ACTIVE is the mode register driving the pads; mode 00 -> pad_out=periph_out, pad_oeb=periph_oeb; mode 01 -> pad_out=OUT bit, pad_oeb=0; modes 10/11 -> pad_out=0, pad_oeb=1.
REQ-019 periph_in = synchronized pad_in where the ACTIVE mode is 00, else 0.
REQ-020 pad_in passes through a 2-flop synchronizer; IN registers reflect pad_in two cycles after it changes.
REQ-021 FSM states IDLE, DRAIN, APPLY.
REQ-022 IDLE -> DRAIN when SHADOW != ACTIVE; on entry latch MASK = per-pad (SHADOW != ACTIVE) and load counter = GUARD.
REQ-023 In DRAIN, masked pads drive pad_out=0, pad_oeb=1; unmasked pads follow ACTIVE.
REQ-024 DRAIN lasts GUARD+1 cycles (GUARD=0 gives 1 cycle), then APPLY.
REQ-025 APPLY (1 cycle): ACTIVE[p] <= SHADOW[p] for masked pads only; masked pads stay tristated; next state IDLE, which re-enters DRAIN if SHADOW != ACTIVE.
REQ-026 BUSY = state != IDLE; PEND = 1 when SHADOW differs from ACTIVE on any unmasked pad.
REQ-027 A SEL write during DRAIN/APPLY that changes a masked pad again takes effect only in the next sequence.
REQ-028 A GUARD write during DRAIN does not alter the running counter.
REQ-029 Writes to OUT take effect the cycle after ack, including during DRAIN.

Reset
REQ-030 On reset: SHADOW and ACTIVE = all 10, MASK=0, OUT=0, GUARD=GUARD_RST, state IDLE, synchronizers 0, ack=0, dat_o=0; pad_out=0, pad_oeb all 1, periph_in=0.
REQ-031 Reset during DRAIN/APPLY aborts the sequence; nothing is applied.

Verification
V1 Release reset, read CTRL -> 0x0000_0008; pad_oeb all 1.
V2 GUARD=3, write SEL0=0x0000_0000 -> pads 0-15 tristated for 4 DRAIN cycles, then APPLY, then pad_oeb[15:0]=periph_oeb[15:0]; BUSY high for 5 cycles.
V3 SEL0 pad0=01, OUT_LO=1 -> after sequence pad_out[0]=1, pad_oeb[0]=0; OUT_LO=0 -> pad_out[0]=0 the cycle after ack.
V4 During DRAIN, write SEL1 pad16=00 -> PEND=1; second sequence follows immediately; pad16 is in peripheral mode after both sequences.
V5 Toggle pad_in[5] -> IN_LO bit5 changes 2 cycles later; periph_in[5] is 0 unless the pad is in mode 00.
V6 Assert wb_rst_i mid-DRAIN -> all pads tristated, SEL0 reads 0xAAAA_AAAA, BUSY=0.
